// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write port, issue port and NUM_RD packed read ports.
// The master side drives requests and the slave side (the register file) returns data, pending flags and ready.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic                     iss;
  logic [ADDR_W-1:0]        iss_addr;
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rpend;
  logic                     ready;

  // No handshake: requests act on the rising edge while ready is high.
  // Read ports are combinational, and they are qualified per port by re.
  modport master (
    output we, waddr, wdata, iss, iss_addr, re, raddr,
    input  rdata, rpend, ready
  );

  modport slave (
    input  we, waddr, wdata, iss, iss_addr, re, raddr,
    output rdata, rpend, ready
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with per-register pending (scoreboard) bits and a
// hardware clear sequence after reset. Optional write-to-read forwarding: RF_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic         clk,
  input  logic         rstn,
  regfile_mp_if.slave  bus,
  output logic         dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                clr_last;
  logic                clr_en;
  logic                run_en;
  logic                wr_en;
  logic                iss_en;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    pending;
  logic [ADDR_W-1:0]   ra [NUM_RD];

  assign clr_last = (clr_cnt == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (!rstn) state <= CLEAR;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      CLEAR:   if (clr_last) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = CLEAR;
    endcase
  end

  // rstn gates the decoded enables so every output reads idle while reset is held.
  always_comb begin
    clr_en = 1'b0;
    run_en = 1'b0;
    if (rstn) begin
      case (state)
        CLEAR:   clr_en = 1'b1;
        RUN:     run_en = 1'b1;
        default: clr_en = 1'b0;
      endcase
    end
  end

  assign bus.ready = run_en;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rstn)       clr_cnt <= '0;
    else if (clr_en) clr_cnt <= clr_cnt + 1'b1;
  end

  assign wr_en  = run_en & bus.we  & (bus.waddr    != '0);
  assign iss_en = run_en & bus.iss & (bus.iss_addr != '0);

  always_ff @(posedge clk) begin
    if (clr_en)     mem[clr_cnt]   <= '0;
    else if (wr_en) mem[bus.waddr] <= bus.wdata;
  end

  // Issue is applied after the write-back clear, so a same-address collision stays pending.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pending <= '0;
    end else begin
      if (wr_en)  pending[bus.waddr]    <= 1'b0;
      if (iss_en) pending[bus.iss_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_ra
    assign ra[k] = bus.raddr[k*ADDR_W +: ADDR_W];
  end

  always_comb begin
    bus.rdata = '0;
    bus.rpend = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (run_en && bus.re[k] && (ra[k] != '0)) begin
        bus.rdata[k*DATA_W +: DATA_W] = mem[ra[k]];
        bus.rpend[k]                  = pending[ra[k]];
`ifdef RF_BYPASS_EN
        if (wr_en && (bus.waddr == ra[k])) bus.rdata[k*DATA_W +: DATA_W] = bus.wdata;
`else
        if (wr_en && (bus.waddr == ra[k])) bus.rdata[k*DATA_W +: DATA_W] = mem[ra[k]];
`endif
      end
    end
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W entries.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (legal range 1..4).
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port we  input  1  write enable.
REQ-007 SHALL have port waddr  input  ADDR_W  write address.
REQ-008 SHALL have port wdata  input  DATA_W  write data.
REQ-009 SHALL have port iss  input  1  issue strobe; marks iss_addr as pending.
REQ-010 SHALL have port iss_addr  input  ADDR_W  destination register being issued.
REQ-011 SHALL have port re  input  NUM_RD  per-port read enable.
REQ-012 SHALL have port raddr  input  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-013 SHALL have port rdata  output  NUM_RD*DATA_W  packed read data; port k at bits [k*DATA_W +: DATA_W].
REQ-014 SHALL have port rpend  output  NUM_RD  per-port pending flag of addressed register.
REQ-015 SHALL have port ready  output  1  high once initial clear is complete.

Function
REQ-016 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-017 In CLEAR, SHALL zero one entry per cycle at clr_cnt (0..DEPTH-1), incrementing clr_cnt; after writing entry DEPTH-1, SHALL enter RUN next cycle.
REQ-018 Initial clear latency SHALL be exactly DEPTH cycles after the first cycle with rstn high; ready rises on the following edge and stays high until next reset.
REQ-019 In CLEAR, SHALL ignore we and iss, force rdata to 0 and rpend to 0.
REQ-020 In RUN, SHALL write wdata to waddr on the edge when we=1 and waddr!=0.
REQ-021 Reads SHALL be combinational: rdata port k = entry[raddr_k] when re[k]=1, else 0.
REQ-022 Register 0 SHALL always read 0, ignore writes, and never be pending.
REQ-023 In RUN, iss=1 with iss_addr!=0 SHALL set pending[iss_addr] on the edge.
REQ-024 In RUN, we=1 with waddr!=0 SHALL clear pending[waddr] on the edge.
REQ-025 Simultaneous iss and we to the same nonzero address SHALL leave pending set (set wins) and still write the data.
REQ-026 rpend[k] SHALL equal pending[raddr_k] & re[k], reflecting registered state (no bypass of same-cycle iss/we).
REQ-027 All read ports SHALL be independent; identical addresses on multiple ports SHALL return identical data.

Reset
REQ-028 rstn=0 at a rising edge SHALL enter CLEAR, set clr_cnt=0, ready=0, clear all pending bits.
REQ-029 Reset asserted mid-CLEAR or during RUN SHALL restart the full clear sequence from entry 0.
REQ-030 While rstn=0, outputs SHALL be rdata=0, rpend=0, ready=0.

Configuration
REQ-031 Macro RF_BYPASS_EN SHALL control write-to-read forwarding.
REQ-032 With RF_BYPASS_EN defined, in RUN, when we=1, waddr!=0, re[k]=1 and raddr_k==waddr, rdata port k SHALL equal wdata in the same cycle.
REQ-033 Without RF_BYPASS_EN, rdata SHALL show the stored value; new data visible the cycle after the write edge.

Verification (DATA_W=32, ADDR_W=5, NUM_RD=2)
REQ-034 rstn low 2 cycles then high -> ready=0 for 32 cycles, ready=1 on cycle 33; all 32 entries read 0x00000000.
REQ-035 RUN: we=1 waddr=5 wdata=0xDEADBEEF; next cycle re=2'b11 raddr={5,5} -> both ports read 0xDEADBEEF; waddr=0 wdata=0x1234 -> reg0 reads 0.
REQ-036 iss=1 iss_addr=7 -> next cycle rpend=1 for raddr=7; we=1 waddr=7 wdata=0x55 -> next cycle rpend=0, rdata=0x55; same-cycle iss+we to 9 -> rpend stays 1.
REQ-037 RF_BYPASS_EN defined: we=1 waddr=3 wdata=0xA5A5A5A5 with raddr0=3 -> rdata port0=0xA5A5A5A5 same cycle; undefined -> old value same cycle, new value next cycle.
REQ-038 rstn pulsed low at clear cycle 10 -> clear restarts, ready rises 33 cycles after rstn returns high; prior contents (e.g. reg5=0xDEADBEEF) read 0.
REQ-039 During CLEAR: we=1 waddr=4 wdata=0xFF, iss to 4 -> after ready, reg4 reads 0 and rpend=0.
